// File: rtl/hp_fpu_pkg.sv
// Shared definitions for the half-precision FPU sequencer and its helpers.
// Contents: widths, opcode encoding ({op[2:1], sr}, matches hp_top), class codes,
// flag bit positions, FSM state type, and the SR LFSR tap mask / step function.
package hp_fpu_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned OP_W   = 3;
    localparam int unsigned FLAG_W = 6;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned LFSR_W = 16;

    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

    // Full opcode; bit0 selects stochastic rounding.
    typedef enum logic [2:0] {
        ADD_RN = 3'b000,
        ADD_SR = 3'b001,
        SUB_RN = 3'b010,
        SUB_SR = 3'b011,
        MUL_RN = 3'b100,
        MUL_SR = 3'b101,
        DIV_RN = 3'b110,
        DIV_SR = 3'b111
    } fpu_op_e;

    // Operation class, op[2:1].
    typedef enum logic [1:0] {
        OPC_ADD = 2'b00,
        OPC_SUB = 2'b01,
        OPC_MUL = 2'b10,
        OPC_DIV = 2'b11
    } fpu_opc_e;

    // Bit positions inside the 6-bit flag word {zero,inf,subN,Norm,QNan,SNan}.
    typedef enum int unsigned {
        FLAG_SNAN = 0,
        FLAG_QNAN = 1,
        FLAG_NORM = 2,
        FLAG_SUBN = 3,
        FLAG_INF  = 4,
        FLAG_ZERO = 5
    } flag_idx_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // One step of the right-shifting Galois LFSR.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

endpackage

// File: rtl/hp_fpu_ctrl_if.sv
// Request/response channel between the core and hp_fpu_ctrl.
// Request : req_valid, req_ready, req_op[2:0], req_a[15:0], req_b[15:0]
// Response: resp_valid, resp_ready, resp_res[15:0], resp_flags[5:0]
// master = requester (core side), slave = controller.
interface hp_fpu_ctrl_if;
    import hp_fpu_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic [OP_W-1:0]   req_op;
    logic [DATA_W-1:0] req_a;
    logic [DATA_W-1:0] req_b;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_res;
    logic [FLAG_W-1:0] resp_flags;

    modport master (
        output req_valid, req_op, req_a, req_b, resp_ready,
        input  req_ready, resp_valid, resp_res, resp_flags
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, resp_ready,
        output req_ready, resp_valid, resp_res, resp_flags
    );
endinterface

// File: rtl/hp_sr_lfsr.sv
// 16-bit Galois LFSR (right shift, tap mask 16'hB400) feeding stochastic rounding.
// Ports: clk, rst_n (async active-low, reloads SEED), adv_i (step once this cycle),
//        state_o[15:0] (current LFSR state).
module hp_sr_lfsr
    import hp_fpu_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              adv_i,
    output logic [LFSR_W-1:0] state_o
);
    logic [LFSR_W-1:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = adv_i ? lfsr_next(lfsr_q) : lfsr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr_q <= SEED;
        else        lfsr_q <= lfsr_d;
    end

    assign state_o = lfsr_q;
endmodule

// File: rtl/hp_fpu_ctrl.sv
// Sequencer between the core and the half-precision FPU datapath: accepts one op,
// drives registered operands/opcode to the datapath, waits an op-dependent latency,
// captures result/flags and returns them on the response channel. Owns the SR LFSR.
// Ports: clk, rst_n; bus (hp_fpu_ctrl_if.slave: req_*/resp_*);
//        dp_a, dp_b, dp_op, sr_rand -> datapath; dp_res, dp_flags <- datapath;
//        busy (state != IDLE).
// Optional: define HP_CTRL_PERF_CNT_EN to add perf_ops / perf_stall counters.
module hp_fpu_ctrl
    import hp_fpu_pkg::*;
#(
    parameter int unsigned       ADD_LAT   = 1,
    parameter int unsigned       MUL_LAT   = 1,
    parameter int unsigned       DIV_LAT   = 12,
    parameter int unsigned       RAND_W    = 12,
    parameter logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1
) (
    input  logic               clk,
    input  logic               rst_n,
    hp_fpu_ctrl_if.slave       bus,
    output logic [DATA_W-1:0]  dp_a,
    output logic [DATA_W-1:0]  dp_b,
    output logic [OP_W-1:0]    dp_op,
    output logic [RAND_W-1:0]  sr_rand,
    input  logic [DATA_W-1:0]  dp_res,
    input  logic [FLAG_W-1:0]  dp_flags,
    output logic               busy
`ifdef HP_CTRL_PERF_CNT_EN
    ,
    output logic [31:0]        perf_ops,
    output logic [31:0]        perf_stall
`endif
);
    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, lat_m1;
    logic [DATA_W-1:0] dp_a_q, dp_a_d, dp_b_q, dp_b_d, res_q, res_d;
    logic [OP_W-1:0]   dp_op_q, dp_op_d;
    logic [FLAG_W-1:0] flags_q, flags_d;
    logic              valid_q, valid_d;
    logic [RAND_W-1:0] rand_q, rand_d;
    logic              ready_c, accept, lfsr_adv;
    logic [LFSR_W-1:0] lfsr_state;

    // Ready in IDLE, or in RESP when the result is being taken (zero-bubble reuse).
    assign ready_c  = (state_q == ST_IDLE) || ((state_q == ST_RESP) && bus.resp_ready);
    assign accept   = ready_c && bus.req_valid;
    assign lfsr_adv = accept && bus.req_op[0];

    hp_sr_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk     (clk),
        .rst_n   (rst_n),
        .adv_i   (lfsr_adv),
        .state_o (lfsr_state)
    );

    // Counter load value: latency minus one for the incoming op class.
    always_comb begin
        case (fpu_opc_e'(bus.req_op[2:1]))
            OPC_ADD, OPC_SUB: lat_m1 = CNT_W'(ADD_LAT - 1);
            OPC_MUL:          lat_m1 = CNT_W'(MUL_LAT - 1);
            OPC_DIV:          lat_m1 = CNT_W'(DIV_LAT - 1);
            default:          lat_m1 = CNT_W'(ADD_LAT - 1);
        endcase
    end

    // Next-state and datapath/response register updates.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dp_a_d  = dp_a_q;
        dp_b_d  = dp_b_q;
        dp_op_d = dp_op_q;
        rand_d  = rand_q;
        res_d   = res_q;
        flags_d = flags_q;
        valid_d = valid_q;

        case (state_q)
            ST_IDLE: ;
            ST_EXEC: begin
                if (cnt_q == '0) begin
                    res_d   = dp_res;
                    flags_d = dp_flags;
                    valid_d = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (bus.resp_ready) begin
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Accept overrides the RESP->IDLE exit so back-to-back ops skip IDLE.
        if (accept) begin
            dp_a_d  = bus.req_a;
            dp_b_d  = bus.req_b;
            dp_op_d = bus.req_op;
            cnt_d   = lat_m1;
            rand_d  = bus.req_op[0] ? RAND_W'(lfsr_state) : '0;
            state_d = ST_EXEC;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            dp_a_q  <= '0;
            dp_b_q  <= '0;
            dp_op_q <= '0;
            rand_q  <= '0;
            res_q   <= '0;
            flags_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dp_a_q  <= dp_a_d;
            dp_b_q  <= dp_b_d;
            dp_op_q <= dp_op_d;
            rand_q  <= rand_d;
            res_q   <= res_d;
            flags_q <= flags_d;
            valid_q <= valid_d;
        end
    end

    assign bus.req_ready  = ready_c;
    assign bus.resp_valid = valid_q;
    assign bus.resp_res   = res_q;
    assign bus.resp_flags = flags_q;
    assign dp_a           = dp_a_q;
    assign dp_b           = dp_b_q;
    assign dp_op          = dp_op_q;
    assign sr_rand        = rand_q;
    assign busy           = (state_q != ST_IDLE);

`ifdef HP_CTRL_PERF_CNT_EN
    logic [31:0] perf_ops_q, perf_stall_q;

    // Completed response handshakes and cycles a ready result waits on the consumer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_ops_q   <= '0;
            perf_stall_q <= '0;
        end else begin
            if ((state_q == ST_RESP) && bus.resp_ready)  perf_ops_q   <= perf_ops_q + 32'd1;
            if ((state_q == ST_RESP) && !bus.resp_ready) perf_stall_q <= perf_stall_q + 32'd1;
        end
    end

    assign perf_ops   = perf_ops_q;
    assign perf_stall = perf_stall_q;
`endif
endmodule

// File: tb/tb_hp_fpu_ctrl.sv
// Self-checking bench for hp_fpu_ctrl: directed steps plus randomized ops against
// a behavioural model (per-op latency table, LFSR sequence, datapath stub).
module tb_hp_fpu_ctrl;
    import hp_fpu_pkg::*;

    localparam int unsigned ADD_LAT_P = 4;
    localparam int unsigned MUL_LAT_P = 2;
    localparam int unsigned DIV_LAT_P = 12;
    localparam int unsigned RAND_W_P  = 12;

    logic        clk;
    logic        rst_n;
    logic [15:0] dp_a, dp_b, dp_res;
    logic [2:0]  dp_op;
    logic [5:0]  dp_flags;
    logic [11:0] sr_rand;
    logic        busy;
`ifdef HP_CTRL_PERF_CNT_EN
    logic [31:0] perf_ops, perf_stall;
`endif

    hp_fpu_ctrl_if bus ();

    hp_fpu_ctrl #(
        .ADD_LAT   (ADD_LAT_P),
        .MUL_LAT   (MUL_LAT_P),
        .DIV_LAT   (DIV_LAT_P),
        .RAND_W    (RAND_W_P),
        .LFSR_SEED (16'hACE1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .dp_a     (dp_a),
        .dp_b     (dp_b),
        .dp_op    (dp_op),
        .sr_rand  (sr_rand),
        .dp_res   (dp_res),
        .dp_flags (dp_flags),
        .busy     (busy)
`ifdef HP_CTRL_PERF_CNT_EN
        ,
        .perf_ops   (perf_ops),
        .perf_stall (perf_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] m_lfsr;
    logic [2:0]  cur_op;
    logic [15:0] cur_a, cur_b, exp_res;
    logic [5:0]  exp_flags;
    logic [11:0] exp_sr;
    int          exp_lat;
    int          m_ops = 0;
    int          m_stall = 0;

    // Datapath stub: 1.0 * x = x (Norm); otherwise a deterministic mix of the inputs.
    function automatic logic [21:0] dp_fn(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [15:0] r;
        if (op[2:1] == 2'b10 && a == 16'h3C00) return {6'b000100, b};
        r = (a ^ {b[7:0], b[15:8]}) + {13'd0, op};
        return {r[5:0] ^ r[15:10], r};
    endfunction

    assign {dp_flags, dp_res} = dp_fn(dp_op, dp_a, dp_b);

    function automatic logic [15:0] galois_step(input logic [15:0] v);
        logic [15:0] n;
        n = v >> 1;
        if (v[0]) n = n ^ 16'hB400;
        return n;
    endfunction

    function automatic int lat_of(input logic [2:0] op);
        case (op[2:1])
            2'b10:   return MUL_LAT_P;
            2'b11:   return DIV_LAT_P;
            default: return ADD_LAT_P;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a request and record what the model expects for it.
    task automatic drive_req(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        cur_op = op;
        cur_a  = a;
        cur_b  = b;
        {exp_flags, exp_res} = dp_fn(op, a, b);
        exp_lat = lat_of(op);
        if (op[0]) begin
            exp_sr = m_lfsr[11:0];
            m_lfsr = galois_step(m_lfsr);
        end else begin
            exp_sr = '0;
        end
    endtask

    // Accept the pending request, follow EXEC, and check latency and captured result.
    task automatic run_exec();
        int cyc;
        #1;
        chk("req_ready_at_offer", 32'(bus.req_ready), 1);
        @(negedge clk);
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b0;
        cyc = 1;
        while (bus.resp_valid !== 1'b1 && cyc <= 40) begin
            chk("exec_busy", 32'(busy), 1);
            chk("exec_req_ready", 32'(bus.req_ready), 0);
            chk("exec_dp_a", 32'(dp_a), 32'(cur_a));
            chk("exec_dp_b", 32'(dp_b), 32'(cur_b));
            chk("exec_dp_op", 32'(dp_op), 32'(cur_op));
            chk("exec_sr_rand", 32'(sr_rand), 32'(exp_sr));
            @(negedge clk);
            cyc++;
        end
        chk("latency", 32'(cyc), 32'(exp_lat + 1));
        chk("resp_res", 32'(bus.resp_res), 32'(exp_res));
        chk("resp_flags", 32'(bus.resp_flags), 32'(exp_flags));
    endtask

    task automatic stall(input int n);
        for (int i = 0; i < n; i++) begin
            chk("stall_valid", 32'(bus.resp_valid), 1);
            chk("stall_res", 32'(bus.resp_res), 32'(exp_res));
            chk("stall_req_ready", 32'(bus.req_ready), 0);
            chk("stall_busy", 32'(busy), 1);
            @(negedge clk);
            m_stall++;
        end
    endtask

    task automatic take();
        chk("take_valid", 32'(bus.resp_valid), 1);
        chk("take_res", 32'(bus.resp_res), 32'(exp_res));
        bus.resp_ready = 1'b1;
        #1;
        chk("take_req_ready", 32'(bus.req_ready), 1);
        @(negedge clk);
        bus.resp_ready = 1'b0;
        m_ops++;
        #1;
        chk("after_take_valid", 32'(bus.resp_valid), 0);
        chk("after_take_busy", 32'(busy), 0);
    endtask

    // Take the current response and offer the next request in the same cycle.
    task automatic chain(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        bus.resp_ready = 1'b1;
        m_ops++;
        drive_req(op, a, b);
        run_exec();
    endtask

    initial begin
        logic [2:0]  rop;
        logic [15:0] ra, rb;

        rst_n          = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_op     = '0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.resp_ready = 1'b0;
        m_lfsr         = 16'hACE1;
        repeat (2) @(negedge clk);
        chk("rst_resp_valid", 32'(bus.resp_valid), 0);
        chk("rst_req_ready", 32'(bus.req_ready), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_resp_res", 32'(bus.resp_res), 0);
        chk("rst_resp_flags", 32'(bus.resp_flags), 0);
        chk("rst_dp_a", 32'(dp_a), 0);
        chk("rst_dp_b", 32'(dp_b), 0);
        chk("rst_dp_op", 32'(dp_op), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_busy", 32'(busy), 0);

        // 1.0 * 2.0
        drive_req(MUL_RN, 16'h3C00, 16'h4000);
        run_exec();
        chk("mul_1x2_res", 32'(bus.resp_res), 32'h4000);
        chk("mul_1x2_flags", 32'(bus.resp_flags), 32'h04);
        take();

        // SR sequence with an RN op in between.
        drive_req(MUL_SR, 16'h1234, 16'h5678);
        run_exec();
        chk("sr_first", 32'(sr_rand), 32'hCE1);
        take();
        drive_req(ADD_RN, 16'h0F0F, 16'hA5A5);
        run_exec();
        chk("rn_sr_zero", 32'(sr_rand), 0);
        take();
        drive_req(SUB_SR, 16'h4444, 16'h2222);
        run_exec();
        chk("sr_second", 32'(sr_rand), 32'h270);
        take();

        // DIV with a 5-cycle consumer stall.
        drive_req(DIV_RN, 16'h4200, 16'h3800);
        run_exec();
        stall(5);
        take();

        // Back-to-back with no IDLE gap.
        drive_req(MUL_RN, 16'hBEEF, 16'h0101);
        run_exec();
        chain(DIV_SR, 16'hCAFE, 16'h7777);
        chain(ADD_RN, 16'h0001, 16'hFFFF);
        stall(2);
        take();

        // Reset in the middle of EXEC.
        drive_req(ADD_SR, 16'h1111, 16'h2222);
        #1;
        chk("rstx_offer_ready", 32'(bus.req_ready), 1);
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("rstx_busy_before", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("rstx_busy", 32'(busy), 0);
        chk("rstx_resp_valid", 32'(bus.resp_valid), 0);
        chk("rstx_req_ready", 32'(bus.req_ready), 1);
        chk("rstx_dp_op", 32'(dp_op), 0);
        m_lfsr  = 16'hACE1;
        m_ops   = 0;
        m_stall = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("rstx_no_resp", 32'(bus.resp_valid), 0);
            chk("rstx_idle", 32'(busy), 0);
            chk("rstx_ready_idle", 32'(bus.req_ready), 1);
        end
        drive_req(MUL_SR, 16'h3C00, 16'hC000);
        run_exec();
        chk("sr_after_reset", 32'(sr_rand), 32'hCE1);
        take();

        // Randomized ops, stalls and back-to-back chaining.
        rop = 3'($urandom_range(0, 7));
        ra  = 16'($urandom());
        rb  = 16'($urandom());
        drive_req(rop, ra, rb);
        run_exec();
        for (int i = 0; i < 30; i++) begin
            stall(int'($urandom_range(0, 3)));
            rop = 3'($urandom_range(0, 7));
            ra  = 16'($urandom());
            rb  = 16'($urandom());
            if ($urandom_range(0, 1) == 1) begin
                chain(rop, ra, rb);
            end else begin
                take();
                drive_req(rop, ra, rb);
                run_exec();
            end
        end
        stall(1);
        take();

`ifdef HP_CTRL_PERF_CNT_EN
        chk("perf_ops", perf_ops, 32'(m_ops));
        chk("perf_stall", perf_stall, 32'(m_stall));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
